// File: rtl/wb_trace_collector_pkg.sv
// Shared definitions for the retired-write trace collector: event kinds,
// entry width and the bit layout of one packed trace entry.
package wb_trace_collector_pkg;

    localparam logic KIND_GRF = 1'b0;
    localparam logic KIND_DM  = 1'b1;

    localparam int TRACE_W  = 97;
    localparam int DATA_LSB = 0;
    localparam int ADDR_LSB = 32;
    localparam int PC_LSB   = 64;
    localparam int KIND_BIT = 96;

    typedef logic [TRACE_W-1:0] trace_entry_t;

    function automatic trace_entry_t pack_entry(
        input logic        kind,
        input logic [31:0] pc,
        input logic [31:0] addr,
        input logic [31:0] data
    );
        return {kind, pc, addr, data};
    endfunction

endpackage

// File: rtl/wb_trace_collector_fifo.sv
// Trace FIFO with two write ports (push0 lands before push1) and one read port.
// The head entry is presented combinationally so an accepted event is visible one edge later.
module wb_trace_collector_fifo
    import wb_trace_collector_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push0,
    input  logic [TRACE_W-1:0] data0,
    input  logic               push1,
    input  logic [TRACE_W-1:0] data1,
    input  logic               pop,
    output logic [TRACE_W-1:0] head,
    output logic [AW:0]        count,
    output logic [AW:0]        free
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [TRACE_W-1:0] mem [DEPTH];
    logic [AW-1:0]      rd_ptr_reg;
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW:0]        count_reg;
    logic [1:0]         push_n;
    logic [AW-1:0]      wr_ptr1;

    assign push_n  = {1'b0, push0} + {1'b0, push1};
    // Second write goes into the slot after the first only when the first is used.
    assign wr_ptr1 = wr_ptr_reg + AW'(push0);

    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr_reg] <= data0;
        if (push1) mem[wr_ptr1]    <= data1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_reg + AW'(pop);
            wr_ptr_reg <= wr_ptr_reg + AW'(push_n);
            count_reg  <= count_reg + (AW+1)'(push_n) - (AW+1)'(pop);
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign free  = DEPTH_L - count_reg + (AW+1)'(pop);

endmodule

// File: rtl/wb_trace_collector.sv
// Merges W-stage register writes and M-stage stores into one ordered event stream,
// dropping (and flagging) whatever does not fit in the FIFO this cycle.
module wb_trace_collector
    import wb_trace_collector_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        grf_we,
    input  logic [31:0] grf_pc,
    input  logic [4:0]  grf_addr,
    input  logic [31:0] grf_wdata,
    input  logic        dm_we,
    input  logic [31:0] dm_pc,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_kind,
    output logic [31:0] out_pc,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic [31:0] ev_count,
    output logic        overflow
);

    logic               g_valid;
    logic               d_valid;
    trace_entry_t       grf_entry;
    trace_entry_t       dm_entry;
    logic               push0;
    logic               push1;
    trace_entry_t       data0;
    logic               drop;
    logic               pop;
    trace_entry_t       head;
    logic [AW:0]        count;
    logic [AW:0]        free;
    logic [31:0]        ev_count_reg;
    logic               overflow_reg;

    assign g_valid   = grf_we && (grf_addr != 5'd0);
    assign d_valid   = dm_we;
    assign grf_entry = pack_entry(KIND_GRF, grf_pc, {27'd0, grf_addr}, grf_wdata);
    assign dm_entry  = pack_entry(KIND_DM, dm_pc, dm_addr, dm_wdata);

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    // The W instruction is older than the M one, so GRF always takes port 0
    // and is the survivor when only one slot is free.
    always_comb begin
        push0 = 1'b0;
        push1 = 1'b0;
        drop  = 1'b0;
        data0 = g_valid ? grf_entry : dm_entry;
        if (g_valid && d_valid) begin
            if (free >= (AW+1)'(2)) begin
                push0 = 1'b1;
                push1 = 1'b1;
            end else if (free == (AW+1)'(1)) begin
                push0 = 1'b1;
                drop  = 1'b1;
            end else begin
                drop  = 1'b1;
            end
        end else if (g_valid || d_valid) begin
            if (free != '0) push0 = 1'b1;
            else            drop  = 1'b1;
        end
    end

    wb_trace_collector_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push0 (push0),
        .data0 (data0),
        .push1 (push1),
        .data1 (dm_entry),
        .pop   (pop),
        .head  (head),
        .count (count),
        .free  (free)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ev_count_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            ev_count_reg <= ev_count_reg + 32'(push0) + 32'(push1);
            if (drop) overflow_reg <= 1'b1;
        end
    end

    assign ev_count = ev_count_reg;
    assign overflow = overflow_reg;
    assign out_kind = head[KIND_BIT];
    assign out_pc   = head[PC_LSB +: 32];
    assign out_addr = head[ADDR_LSB +: 32];
    assign out_data = head[DATA_LSB +: 32];

endmodule

// File: tb/tb_wb_trace_collector.sv
// Randomized + directed bench: a queue model of the trace FIFO feeds a scoreboard
// that an independent negedge monitor drains whenever the DUT hands off an event.
module tb_wb_trace_collector;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        grf_we = 1'b0;
    logic [31:0] grf_pc = '0;
    logic [4:0]  grf_addr = '0;
    logic [31:0] grf_wdata = '0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_pc = '0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_kind;
    logic [31:0] out_pc;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [31:0] ev_count;
    logic        overflow;

    wb_trace_collector #(.DEPTH(DEPTH), .AW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .grf_we    (grf_we),
        .grf_pc    (grf_pc),
        .grf_addr  (grf_addr),
        .grf_wdata (grf_wdata),
        .dm_we     (dm_we),
        .dm_pc     (dm_pc),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_kind  (out_kind),
        .out_pc    (out_pc),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .ev_count  (ev_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    logic [96:0] mq[$];   // model FIFO contents
    logic [96:0] sb[$];   // expected output order
    logic [31:0] exp_evc = '0;
    logic        exp_ovf = 1'b0;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [96:0] act, input logic [96:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: compares steady-state outputs and pops the scoreboard on each handshake.
    initial begin
        logic [96:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("out_valid", 97'(out_valid), 97'(mq.size() != 0));
                chk("ev_count", 97'(ev_count), 97'(exp_evc));
                chk("overflow", 97'(overflow), 97'(exp_ovf));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 97'(1), 97'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("entry", {out_kind, out_pc, out_addr, out_data}, e);
                        $display("pop kind=%0d pc=%h addr=%h data=%h", out_kind, out_pc, out_addr, out_data);
                    end
                end
            end
        end
    end

    // One clock of stimulus: the model decides what the FIFO accepts from the
    // currently driven inputs, then the result is committed after the edge.
    task automatic step();
        logic [96:0] ev[$];
        int sz, free, acc;
        bit pop;
        sz   = mq.size();
        pop  = (sz > 0) && out_ready;
        free = DEPTH - sz + int'(pop);
        if (grf_we && grf_addr != 5'd0)
            ev.push_back({1'b0, grf_pc, 27'd0, grf_addr, grf_wdata});
        if (dm_we)
            ev.push_back({1'b1, dm_pc, dm_addr, dm_wdata});
        acc = (ev.size() <= free) ? ev.size() : free;
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        for (int i = 0; i < acc; i++) begin
            mq.push_back(ev[i]);
            sb.push_back(ev[i]);
        end
        exp_evc = exp_evc + 32'(acc);
        if (ev.size() > acc) exp_ovf = 1'b1;
    endtask

    task automatic idle();
        grf_we = 1'b0;
        dm_we  = 1'b0;
    endtask

    task automatic set_grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        grf_we = 1'b1; grf_pc = pc; grf_addr = a; grf_wdata = d;
    endtask

    task automatic set_dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
        dm_we = 1'b1; dm_pc = pc; dm_addr = a; dm_wdata = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        set_grf($urandom(), 5'd7, $urandom());
        set_dm($urandom(), 32'h40, $urandom());
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        mq.delete();
        sb.delete();
        exp_evc = '0;
        exp_ovf = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        idle();
        out_ready = 1'b1;
        while ((mq.size() != 0 || sb.size() != 0) && budget < 4 * DEPTH) begin
            step();
            budget++;
        end
        chk("drain_bound", 97'(sb.size()), 97'(0));
        out_ready = 1'b0;
    endtask

    task automatic fill(input int n);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            idle();
            set_grf(32'h3000 + 32'(4 * i), 5'($urandom_range(1, 31)), $urandom());
            step();
        end
        idle();
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;
        chk("reset_valid", 97'(out_valid), 97'(0));
        chk("reset_evc", 97'(ev_count), 97'(0));

        // 1: single GRF event, visible one edge later
        out_ready = 1'b1;
        set_grf(32'h3000, 5'd5, 32'h1234);
        step();
        idle();
        chk("t1_valid", 97'(out_valid), 97'(1));
        chk("t1_kind", 97'(out_kind), 97'(0));
        chk("t1_addr", 97'(out_addr), 97'(5));
        chk("t1_data", 97'(out_data), 97'(32'h1234));
        chk("t1_evc", 97'(ev_count), 97'(1));
        step();

        // 2: simultaneous GRF and DM, GRF first
        do_reset();
        set_grf(32'h3004, 5'd3, 32'hA);
        set_dm(32'h3008, 32'h10, 32'hB);
        step();
        idle();
        chk("t2_evc", 97'(ev_count), 97'(2));
        chk("t2_head_kind", 97'(out_kind), 97'(0));
        step();
        chk("t2_hold_data", 97'(out_data), 97'(32'hA));
        drain();

        // 3: write to $0 is ignored, not a drop
        set_grf(32'h300C, 5'd0, 32'hDEAD);
        step();
        idle();
        chk("t3_evc", 97'(ev_count), 97'(2));
        chk("t3_ovf", 97'(overflow), 97'(0));
        chk("t3_valid", 97'(out_valid), 97'(0));

        // 4: full FIFO, dual event dropped entirely
        do_reset();
        fill(16);
        set_grf(32'h4000, 5'd9, 32'h99);
        set_dm(32'h4004, 32'h20, 32'h77);
        step();
        idle();
        chk("t4_ovf", 97'(overflow), 97'(1));
        chk("t4_evc", 97'(ev_count), 97'(16));
        drain();

        // 5: one free slot, GRF kept and DM dropped
        do_reset();
        fill(15);
        set_grf(32'h5000, 5'd11, 32'h55);
        set_dm(32'h5004, 32'h30, 32'h66);
        step();
        idle();
        chk("t5_ovf", 97'(overflow), 97'(1));
        chk("t5_evc", 97'(ev_count), 97'(16));
        drain();

        // 6: full FIFO with pop frees room for a DM event
        do_reset();
        fill(16);
        out_ready = 1'b1;
        set_dm(32'h6000, 32'h44, 32'h1111);
        step();
        idle();
        out_ready = 1'b0;
        chk("t6_ovf", 97'(overflow), 97'(0));
        chk("t6_evc", 97'(ev_count), 97'(17));
        step();
        do_reset();
        chk("t6_rst_valid", 97'(out_valid), 97'(0));
        chk("t6_rst_evc", 97'(ev_count), 97'(0));

        // Random traffic with periodic resets and varying consumer pace
        for (int seg = 0; seg < 8; seg++) begin
            int rdy_pct;
            rdy_pct = (seg % 2 == 0) ? 30 : 85;
            do_reset();
            for (int c = 0; c < 200; c++) begin
                idle();
                if ($urandom_range(0, 99) < 60)
                    set_grf($urandom(), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom()), $urandom());
                if ($urandom_range(0, 99) < 50)
                    set_dm($urandom(), $urandom() & 32'hFFFF_FFFC, $urandom());
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                step();
            end
            drain();
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_trace_collector.md
# wb_trace_collector

Sink-side companion to the `mips` core: it consumes the architectural write events the pipeline retires and merges them into one ordered, buffered event stream. Inputs are the GRF write from W and the DM store from M; the output goes to a downstream logger/comparator. The block is simulation- and debug-facing but fully synthesizable. It sits beside `mips` under the top-level bench and decouples pipeline timing from the consumer's pace.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 4.
- `AW`, 4: log2(DEPTH).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `grf_we` in 1: W-stage register write this cycle.
- `grf_pc` in 32: PC of the W-stage instruction.
- `grf_addr` in 5: destination register.
- `grf_wdata` in 32: write data.
- `dm_we` in 1: M-stage word store this cycle.
- `dm_pc` in 32: PC of the M-stage instruction.
- `dm_addr` in 32: byte address (word aligned).
- `dm_wdata` in 32: store data.
- `out_valid` out 1: head event present.
- `out_ready` in 1: consumer accepts the head event.
- `out_kind` out 1: 0 = GRF write, 1 = DM store.
- `out_pc` out 32: event PC.
- `out_addr` out 32: register number zero-extended (GRF) or byte address (DM).
- `out_data` out 32: write data.
- `ev_count` out 32: events accepted into the FIFO; wraps at 2^32.
- `overflow` out 1: sticky flag, set when any event was dropped.

## Operation
- Valid GRF event: `grf_we && grf_addr != 0`. Writes to $0 are silently ignored and are not counted as drops.
- Valid DM event: `dm_we`.
- When both events are valid in the same cycle, the GRF event is pushed first because the W instruction is older than the M instruction. Both events go into consecutive entries in the same cycle.
- Pop: when `out_valid && out_ready`, the head entry is removed.
- Free slots for this cycle = `DEPTH - count + pop`. A pop in the same cycle frees a slot.
- Push rules when space is short:
  - Pushes needed ≤ free slots: push all of them.
  - One event needed, 0 free: drop it and set `overflow`.
  - Two events needed, 1 free: push the GRF event, drop the DM event, set `overflow`.
  - Two events needed, 0 free: drop both and set `overflow`.
- `ev_count` increments by the number of events actually pushed (0, 1 or 2).
- `overflow` is cleared only by `reset`.
- Entry format: {kind, pc[31:0], addr[31:0], data[31:0]} = 97 bits.
- Pointers are AW bits and wrap modulo DEPTH. `count` is AW+1 bits, range 0..DEPTH.

## Timing
- Reset values: `out_valid` = 0, `ev_count` = 0, `overflow` = 0, pointers and count = 0. `out_kind`/`out_pc`/`out_addr`/`out_data` show the unused head entry and are don't-care while `out_valid` is 0.
- `reset` asserted mid-stream flushes all entries at that edge. Inputs sampled at the reset edge are discarded.
- Latency: an event presented before edge N is visible on the outputs after edge N, provided the FIFO was empty. The outputs are read combinationally from the head entry.
- `out_valid` = (count != 0) and does not depend on `out_ready`.
- Outputs hold stable while `out_valid && !out_ready`.
- Throughput: up to 2 pushes and 1 pop per cycle.
- Full FIFO plus pop plus 1 valid event in the same cycle: the push is accepted and count is unchanged.
- Empty FIFO plus push: no bypass. `out_valid` rises on the next cycle.

## Structure
- Shared header/package `trace_defs`: `KIND_GRF` = 1'b0, `KIND_DM` = 1'b1, `TRACE_W` = 97, and field offsets for kind/pc/addr/data.
- One sub-module, `trace_fifo`: DEPTH×TRACE_W storage with a two-write-port, one-read-port interface (`push0`, `push1`, `pop`, `free`, `count`).
- The top level contains:
  - event qualification;
  - push ordering and drop logic;
  - the `ev_count` and `overflow` registers.

## Test plan
1. Reset, then one GRF event (pc=0x3000, $5, 0x1234) with `out_ready`=1 → one cycle later `out_valid`=1 with kind 0, addr 5, data 0x1234; `ev_count`=1.
2. Same cycle: GRF ($3, 0xA) and DM (addr 0x10, 0xB), `out_ready`=0 → two entries; the first pop shows kind 0, the second kind 1; `ev_count`=2.
3. `grf_we`=1 with `grf_addr`=0 → nothing pushed; `ev_count` and `overflow` unchanged.
4. `out_ready`=0, fill 16 events, then one dual-event cycle → `overflow`=1, count stays 16, `ev_count`=16. Draining shows events in push order with nothing from the dual-event cycle.
5. Count=15, dual event, no pop → GRF accepted, DM dropped, `overflow`=1, count=16.
6. Count=16 with pop and one DM event in the same cycle → push accepted, count stays 16, `overflow` stays 0. Asserting `reset` next → `out_valid`=0, `ev_count`=0.
